oclib_drp_arbiter: RTL
======================

OCLIB_DRP_ARBITER -- requirements
Module: oclib_drp_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter DrpType, default oclib_pkg::drp_s, carries the DRP request struct (enable, write, address, wdata).
REQ-003 Parameter DrpFbType, default oclib_pkg::drp_fb_s, carries the DRP feedback struct (ready, rdata).
REQ-004 Parameter Ports, default 2, sets the number of upstream DRP masters, legal range 2..8.
REQ-005 Parameter TimeoutCycles, default 1023, sets the wait limit in StWait; 0 disables the timeout.
REQ-006 Port clock  input  1  rising-edge clock.
REQ-007 Port resetN  input  1  asynchronous active-low reset.
REQ-008 Port drpIn  input  DrpType[Ports]  upstream requests; enable is a one-cycle pulse.
REQ-009 Port drpInFb  output  DrpFbType[Ports]  per-master completion; ready is a one-cycle pulse.
REQ-010 Port drpOut  output  DrpType  request to the shared DRP target.
REQ-011 Port drpOutFb  input  DrpFbType  target completion.
REQ-012 Port errorTimeout  output  1  one-cycle pulse on a timed-out transaction.
REQ-013 Port errorOverrun  output  1  one-cycle pulse on a dropped request.

Function
REQ-014 Each port SHALL have a pending register; drpIn[p].enable with pending[p] clear SHALL capture write/address/wdata and set pending[p] at that clock edge.
REQ-015 drpIn[p].enable while pending[p] is set SHALL be dropped, leaving the stored request unchanged, and SHALL pulse errorOverrun in the next cycle.
REQ-016 The FSM SHALL have states StIdle and StWait, and SHALL hold a registered grant index and a lastGrant index.
REQ-017 In StIdle with any pending bit set, the FSM SHALL grant the first pending port searching from lastGrant+1 modulo Ports (round-robin).
REQ-018 On grant, drpOut SHALL carry the granted request with enable=1 for exactly one cycle, the timer SHALL clear, and the FSM SHALL move to StWait.
REQ-019 drpOut.enable SHALL be low in every other cycle, and all drpOut fields SHALL be zero when not enabled.
REQ-020 Minimum latency SHALL be: drpIn enable in cycle N gives drpOut.enable in cycle N+2.
REQ-021 In StWait with drpOutFb.ready in cycle M, drpInFb[grant] SHALL give ready=1 and rdata=drpOutFb.rdata in cycle M+1 only.
REQ-022 On that completion, pending[grant] SHALL clear, lastGrant SHALL become grant, and the FSM SHALL return to StIdle.
REQ-023 In StWait with TimeoutCycles>0, the timer SHALL increment each cycle; width is $clog2(TimeoutCycles+1).
REQ-024 If the timer reaches TimeoutCycles before ready, the granted master SHALL receive ready=1 with rdata all ones, and errorTimeout SHALL pulse in the same cycle.
REQ-025 After a timeout, the FSM SHALL clear pending[grant], update lastGrant, and return to StIdle.
REQ-026 drpOutFb.ready while in StIdle (late response) SHALL be ignored and SHALL NOT produce any drpInFb.ready.
REQ-027 drpOutFb.ready and timer expiry in the same cycle SHALL be treated as a normal completion with real rdata and no errorTimeout.
REQ-028 Non-granted drpInFb entries SHALL be all zero, and at most one drpInFb[p].ready SHALL be high in any cycle.
REQ-029 A new enable on a port in the same cycle as that port's completion SHALL be captured as a fresh request, not an overrun.

Reset
REQ-030 While resetN=0, drpOut, all drpInFb entries, errorTimeout and errorOverrun SHALL be zero.
REQ-031 While resetN=0, all pending bits SHALL clear, the timer SHALL be 0, the FSM SHALL be in StIdle, and lastGrant SHALL be Ports-1 so port 0 wins first.
REQ-032 Reset asserted mid-transaction SHALL abandon that transaction with no ready returned upstream.
REQ-033 The first request after reset release SHALL be handled normally.

Verification
REQ-034 Single read: port0 read at address 0x12, target answers rdata 0xBEEF after 3 cycles -> one drpOut.enable at N+2, drpInFb[0].ready with 0xBEEF one cycle after the target ready.
REQ-035 Contention: port0 and port1 enable in the same cycle -> port0 is served first, then port1; a second simultaneous pair is served port0 then port1 again (alternation via lastGrant).
REQ-036 Timeout: TimeoutCycles=8, target never answers -> ready with rdata all ones and errorTimeout after 8 StWait cycles; a late target ready afterwards is ignored.
REQ-037 Overrun: second enable on port1 while its first request is pending -> errorOverrun pulse, first request completes with its original address, only one ready returned.
REQ-038 Reset mid-StWait: resetN low during a port0 read -> outputs zero immediately, no ready to port0, and a subsequent port1 write completes normally.

Source files
------------

// File: rtl/oclib_drp_arbiter.sv
// oclib_drp_arbiter: round-robin sharing of one DRP target among several DRP masters,
// with one buffered request per master, response timeout and overrun reporting.
`timescale 1ns/1ps
`default_nettype none

package oclib_pkg;
  typedef struct packed {
    logic        enable;
    logic        write;
    logic [9:0]  address;
    logic [15:0] wdata;
  } drp_s;

  typedef struct packed {
    logic        ready;
    logic [15:0] rdata;
  } drp_fb_s;
endpackage

module oclib_drp_arbiter #(
  parameter type DrpType       = oclib_pkg::drp_s,
  parameter type DrpFbType     = oclib_pkg::drp_fb_s,
  parameter int  Ports         = 2,
  parameter int  TimeoutCycles = 1023
) (
  input  logic     clock,
  input  logic     resetN,
  input  DrpType   drpIn    [Ports],
  output DrpFbType drpInFb  [Ports],
  output DrpType   drpOut,
  input  DrpFbType drpOutFb,
  output logic     errorTimeout,
  output logic     errorOverrun
);
  localparam int GW = $clog2(Ports);
  localparam int TW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [GW:0]   PORTS_W   = (GW+1)'(Ports);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TimeoutCycles);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  logic [0:0]       state;
  logic [GW-1:0]    grant;
  logic [GW-1:0]    last_grant;
  logic [GW-1:0]    next_grant;
  logic [TW-1:0]    timer;
  logic [Ports-1:0] pending;
  logic [Ports-1:0] req_en;
  logic [Ports-1:0] done_clr;
  DrpType           req [Ports];
  logic             any_pending;
  logic             resp_ok;
  logic             resp_expired;
  logic             finish;
  logic             found;
  logic [GW:0]      cand;

  assign any_pending  = |pending;
  assign resp_ok      = (state == StWait) && drpOutFb.ready;
  // A response arriving in the expiry cycle wins over the timeout.
  assign resp_expired = (TimeoutCycles > 0) && (state == StWait) && !drpOutFb.ready &&
                        (timer == TIMER_MAX);
  assign finish       = resp_ok || resp_expired;

  always_comb begin
    for (int p = 0; p < Ports; p++) begin
      req_en[p]   = drpIn[p].enable;
      done_clr[p] = finish && (grant == GW'(p));
    end
  end

  // Round-robin search starting just after the previously served port.
  always_comb begin
    next_grant = last_grant;
    found      = 1'b0;
    cand       = '0;
    for (int i = 1; i <= Ports; i++) begin
      cand = {1'b0, last_grant} + (GW+1)'(i);
      if (cand >= PORTS_W) cand = cand - PORTS_W;
      if (!found && pending[cand[GW-1:0]]) begin
        found      = 1'b1;
        next_grant = cand[GW-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pending      <= '0;
      errorOverrun <= 1'b0;
      for (int p = 0; p < Ports; p++) req[p] <= '0;
    end else begin
      errorOverrun <= |(req_en & pending & ~done_clr);
      for (int p = 0; p < Ports; p++) begin
        if (req_en[p] && (!pending[p] || done_clr[p])) begin
          pending[p] <= 1'b1;
          req[p]     <= drpIn[p];
        end else if (done_clr[p]) begin
          pending[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state        <= StIdle;
      grant        <= '0;
      last_grant   <= GW'(Ports - 1);
      timer        <= '0;
      drpOut       <= '0;
      errorTimeout <= 1'b0;
      for (int p = 0; p < Ports; p++) drpInFb[p] <= '0;
    end else begin
      drpOut       <= '0;
      errorTimeout <= 1'b0;
      for (int p = 0; p < Ports; p++) drpInFb[p] <= '0;
      case (state)
        StIdle: begin
          if (any_pending) begin
            grant         <= next_grant;
            drpOut        <= req[next_grant];
            drpOut.enable <= 1'b1;
            timer         <= '0;
            state         <= StWait;
          end
        end
        StWait: begin
          if (finish) begin
            drpInFb[grant].ready <= 1'b1;
            drpInFb[grant].rdata <= resp_ok ? drpOutFb.rdata : '1;
            errorTimeout         <= !resp_ok;
            last_grant           <= grant;
            state                <= StIdle;
          end else if (TimeoutCycles > 0) begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule

`default_nettype wire
